// File: rtl/audio_rx_control_pkg.sv
// Shared audio definitions: word sizes and the receive FSM state type.
package audio_rx_control_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned BITS_PER_CH = 16;
  localparam int unsigned CNT_W       = 5;

  // bit_cnt value for a complete channel; also the saturation point
  localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(BITS_PER_CH);

  typedef enum logic [1:0] {
    StWaitSync,
    StLeft,
    StRight
  } audio_state_e;

endpackage

// File: rtl/audio_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise and change
// detection on the synchronized value.
module audio_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic change_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw input through the synchronizer and keep one delayed copy for edge detect
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o      = sync_q[SYNC_STAGES-1];
  assign rise_o   = q_o & ~prev_q;
  assign change_o = q_o ^ prev_q;

endmodule

// File: rtl/audio_rx_control.sv
// Serial audio receiver: synchronizes sclk/lrclk/sdout, assembles 16-bit left/right words
// MSB first and presents a stereo pair with a one-cycle sample_valid pulse.
// Optional build macro AUDIO_RX_FRAME_ERR_EN enables frame_err for malformed channel lengths.
module audio_rx_control #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        audio_sclk,
  input  logic        audio_lrclk,
  input  logic        audio_sdout,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_valid,
  output logic        frame_err
);

  import audio_rx_control_pkg::*;

  logic sclk_s, lr_s, sd_s, sclk_rise;
  logic sclk_change_unused, lr_rise_unused, lr_change_unused, sd_rise_unused, sd_change_unused;

  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i    (clk),
    .rst_ni   (rst),
    .d_i      (audio_sclk),
    .q_o      (sclk_s),
    .rise_o   (sclk_rise),
    .change_o (sclk_change_unused)
  );

  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk_i    (clk),
    .rst_ni   (rst),
    .d_i      (audio_lrclk),
    .q_o      (lr_s),
    .rise_o   (lr_rise_unused),
    .change_o (lr_change_unused)
  );

  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdout (
    .clk_i    (clk),
    .rst_ni   (rst),
    .d_i      (audio_sdout),
    .q_o      (sd_s),
    .rise_o   (sd_rise_unused),
    .change_o (sd_change_unused)
  );

  audio_state_e          state_q, state_d;
  logic                  lr_prev_q, lr_prev_d;
  logic [SAMPLE_W-1:0]   shift_q, shift_d;
  logic [SAMPLE_W-1:0]   left_hold_q, left_hold_d;
  logic [SAMPLE_W-1:0]   left_q, left_d, right_q, right_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  valid_q, valid_d;
  logic                  lr_change;
  logic [3:0]            bit_idx;

  // lrclk is compared against the value captured at the previous sclk edge, not per clk
  assign lr_change = lr_s ^ lr_prev_q;
  // Bit n of a word lands at index 15-n
  assign bit_idx   = ~bit_cnt_q[3:0];

  // Next-state: word assembly and channel FSM, all gated by the sclk rising edge
  always_comb begin
    state_d     = state_q;
    lr_prev_d   = lr_prev_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    bit_cnt_d   = bit_cnt_q;
    valid_d     = 1'b0;
    if (sclk_rise) begin
      lr_prev_d = lr_s;
      if (lr_change) begin
        // The bit that arrives with the lrclk change is the MSB of the new word
        shift_d                = '0;
        shift_d[SAMPLE_W-1]    = sd_s;
        bit_cnt_d              = CNT_W'(1);
        unique case (state_q)
          StWaitSync: if (!lr_s) state_d = StLeft;
          StLeft: if (lr_s) begin
            state_d     = StRight;
            left_hold_d = shift_q;
          end
          StRight: if (!lr_s) begin
            state_d = StLeft;
            left_d  = left_hold_q;
            right_d = shift_q;
            valid_d = 1'b1;
          end
          default: state_d = StWaitSync;
        endcase
      end else if (bit_cnt_q < BITS_FULL) begin
        shift_d[bit_idx] = sd_s;
        bit_cnt_d        = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StWaitSync;
      lr_prev_q   <= 1'b0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      bit_cnt_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lr_prev_q   <= lr_prev_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      bit_cnt_q   <= bit_cnt_d;
      valid_q     <= valid_d;
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;

`ifdef AUDIO_RX_FRAME_ERR_EN
  logic ovf_q, ovf_d, left_err_q, left_err_d, frame_err_q, frame_err_d;
  logic ch_err;

  // bit_cnt saturates, so a separate flag remembers bits that arrived past the full count
  assign ch_err = (bit_cnt_q != BITS_FULL) | ovf_q;

  // Next-state: per-channel length check, reported with the pair's valid pulse
  always_comb begin
    ovf_d       = ovf_q;
    left_err_d  = left_err_q;
    frame_err_d = 1'b0;
    if (sclk_rise) begin
      if (lr_change) begin
        ovf_d = 1'b0;
        if (state_q == StLeft && lr_s)   left_err_d  = ch_err;
        if (state_q == StRight && !lr_s) frame_err_d = left_err_q | ch_err;
      end else if (bit_cnt_q == BITS_FULL) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Frame error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q       <= 1'b0;
      left_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ovf_q       <= ovf_d;
      left_err_q  <= left_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_audio_rx_control.sv
// Self-checking bench for audio_rx_control: table-driven frames, random frames, start-up
// alignment, sclk stall and mid-frame reset, checked against a channel-level model.
module tb_audio_rx_control;

  localparam int SCLK_HALF = 160;   // clk period is 10, sclk period 320
  localparam int STALL     = 10000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        audio_sclk = 1'b0;
  logic        audio_lrclk = 1'b0;
  logic        audio_sdout = 1'b0;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid, frame_err;

  always #5 clk = ~clk;

  audio_rx_control #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .audio_sclk   (audio_sclk),
    .audio_lrclk  (audio_lrclk),
    .audio_sdout  (audio_sdout),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  typedef struct packed {logic [15:0] l; logic [15:0] r; logic e;} pair_t;
  typedef struct {logic lr; logic [15:0] word; int n;} ch_t;
  typedef struct {
    logic [31:0] lbits; int ln; logic [31:0] rbits; int rn;
    logic [15:0] xl; logic [15:0] xr; logic bad;
  } vec_t;

  ch_t   ch_q[$];
  pair_t exp_q[$];
  pair_t got_q[$];
  int    got_rd = 0;
  int    n_assert = 0;
  int    n_fail = 0;
  int    hold_bad = 0;
  logic [15:0] last_l = '0, last_r = '0;

  function automatic logic err_en();
`ifdef AUDIO_RX_FRAME_ERR_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Record every valid pair; between pulses outputs must hold and frame_err stay low
  always @(negedge clk) begin
    if (!rst) begin
      last_l = '0;
      last_r = '0;
    end else if (sample_valid) begin
      got_q.push_back('{l: sample_left, r: sample_right, e: frame_err});
      last_l = sample_left;
      last_r = sample_right;
    end else if (sample_left !== last_l || sample_right !== last_r || frame_err !== 1'b0) begin
      hold_bad++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Channel-level model: a pair is emitted when a left that followed a right is itself
  // followed by a right and then the first bit of the next left
  function automatic void model_add(input logic lr, input logic [31:0] bits, input int n);
    ch_t c;
    logic [31:0] w;
    int j;
    pair_t p;
    w = (n >= 16) ? (bits >> (n - 16)) : (bits << (16 - n));
    c.lr = lr;
    c.word = w[15:0];
    c.n = n;
    ch_q.push_back(c);
    j = ch_q.size() - 1;
    if (j >= 3 && !ch_q[j].lr && ch_q[j-1].lr && !ch_q[j-2].lr && ch_q[j-3].lr) begin
      p.l = ch_q[j-2].word;
      p.r = ch_q[j-1].word;
      p.e = err_en() && (ch_q[j-2].n != 16 || ch_q[j-1].n != 16);
      exp_q.push_back(p);
    end
  endfunction

  task automatic drain(input string tag);
    pair_t g;
    chk({tag, "_pulses"}, 32'(got_q.size() - got_rd), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (got_rd < got_q.size()) begin
        g = got_q[got_rd];
        got_rd++;
        chk({tag, "_left"},  32'(g.l), 32'(exp_q[i].l));
        chk({tag, "_right"}, 32'(g.r), 32'(exp_q[i].r));
        chk({tag, "_ferr"},  32'(g.e), 32'(exp_q[i].e));
      end
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic send_bit(input logic lr, input logic sd);
    audio_lrclk = lr;
    audio_sdout = sd;
    #(SCLK_HALF);
    audio_sclk = 1'b1;
    #(SCLK_HALF);
    audio_sclk = 1'b0;
  endtask

  // ev_kind 1: stall sclk before bit ev_at; ev_kind 2: pulse reset before bit ev_at
  task automatic send_ch(input logic lr, input logic [31:0] bits, input int n,
                         input int ev_at, input int ev_kind);
    model_add(lr, bits, n);
    for (int i = n - 1; i >= 0; i--) begin
      if (n - 1 - i == ev_at && ev_kind == 1) #(STALL);
      if (n - 1 - i == ev_at && ev_kind == 2) begin
        drain("pre_rst");
        #3;
        rst = 1'b0;
        #1;
        chk("rst_left",  32'(sample_left),  32'h0);
        chk("rst_right", 32'(sample_right), 32'h0);
        chk("rst_valid", 32'(sample_valid), 32'h0);
        chk("rst_ferr",  32'(frame_err),    32'h0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        ch_q.delete();
        model_add(lr, 32'h0, i + 1);
      end
      send_bit(lr, bits[i]);
    end
  endtask

  vec_t tbl[6];
  int   base;
  int   ln, rn;
  logic [31:0] lb, rb;

  initial begin
    tbl[0] = '{32'hA5C3, 16, 32'h1234,  16, 16'hA5C3, 16'h1234, 1'b0};
    tbl[1] = '{32'hA5C3, 16, 32'h1234,  16, 16'hA5C3, 16'h1234, 1'b0};
    tbl[2] = '{32'h0FFF, 12, 32'h1234,  16, 16'hFFF0, 16'h1234, 1'b1};
    tbl[3] = '{32'h1234, 16, 32'h80017, 20, 16'h1234, 16'h8001, 1'b1};
    tbl[4] = '{32'hFFFF, 16, 32'h0000,  16, 16'hFFFF, 16'h0000, 1'b0};
    tbl[5] = '{32'h0005,  3, 32'h0001,   1, 16'hA000, 16'h8000, 1'b1};

    // Reset state, with lrclk already high as if mid-right channel
    audio_lrclk = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_left",  32'(sample_left),  32'h0);
    chk("reset_right", 32'(sample_right), 32'h0);
    chk("reset_valid", 32'(sample_valid), 32'h0);
    chk("reset_ferr",  32'(frame_err),    32'h0);
    rst = 1'b1;

    // Start-up alignment: remainder of a right channel must produce nothing
    send_ch(1'b1, 32'h1A5, 9, -1, 0);
    chk("startup_no_valid", 32'(got_q.size()), 32'h0);

    // Table frames, closed by one more left channel
    base = got_q.size();
    foreach (tbl[k]) begin
      send_ch(1'b0, tbl[k].lbits, tbl[k].ln, -1, 0);
      send_ch(1'b1, tbl[k].rbits, tbl[k].rn, -1, 0);
    end
    send_ch(1'b0, 32'h0F0F, 16, -1, 0);
    chk("table_pulses", 32'(got_q.size() - base), 32'($size(tbl)));
    foreach (tbl[k]) begin
      if (base + k < got_q.size()) begin
        chk("table_left",  32'(got_q[base+k].l), 32'(tbl[k].xl));
        chk("table_right", 32'(got_q[base+k].r), 32'(tbl[k].xr));
        chk("table_ferr",  32'(got_q[base+k].e), 32'(tbl[k].bad & err_en()));
      end
    end
    drain("table");

    // Random frames, mostly 16 bits per channel with occasional short/long channels
    repeat (12) begin
      rn = ($urandom_range(3) == 0) ? int'($urandom_range(20, 8)) : 16;
      ln = ($urandom_range(3) == 0) ? int'($urandom_range(20, 8)) : 16;
      rb = $urandom & 32'((64'd1 << rn) - 1);
      lb = $urandom & 32'((64'd1 << ln) - 1);
      send_ch(1'b1, rb, rn, -1, 0);
      send_ch(1'b0, lb, ln, -1, 0);
    end
    drain("random");

    // sclk stall mid-left
    send_ch(1'b1, 32'h1234, 16, -1, 0);
    send_ch(1'b0, 32'hBEEF, 16, 5, 1);
    send_ch(1'b1, 32'h4321, 16, -1, 0);
    send_ch(1'b0, 32'h0001, 16, -1, 0);
    drain("stall");

    // Reset during bit 7 of a left channel, then resynchronize
    send_ch(1'b1, 32'h5555, 16, -1, 0);
    send_ch(1'b0, 32'hA5C3, 16, 7, 2);
    chk("post_rst_no_valid", 32'(got_q.size() - got_rd), 32'h0);
    send_ch(1'b1, 32'h1234, 16, -1, 0);
    send_ch(1'b0, 32'hA5C3, 16, -1, 0);
    send_ch(1'b1, 32'h1234, 16, -1, 0);
    send_ch(1'b0, 32'hC0DE, 16, -1, 0);
    drain("resync");

    chk("hold_stable", 32'(hold_bad), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_rx_control.md
AUDIO_RX_CONTROL -- requirements
Module: audio_rx_control

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for audio_sclk, audio_lrclk and audio_sdout (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single system clock; every flop runs on rising clk.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port audio_sclk, input, 1, the external serial bit clock (asynchronous to clk).
REQ-005 SHALL have port audio_lrclk, input, 1, the external word select: 0 means left, 1 means right.
REQ-006 SHALL have port audio_sdout, input, 1, serial data from the ADC, MSB first.
REQ-007 SHALL have port sample_left, output, 16, the last complete left word.
REQ-008 SHALL have port sample_right, output, 16, the last complete right word.
REQ-009 SHALL have port sample_valid, output, 1, a one-clk pulse when a new stereo pair is presented.
REQ-010 SHALL have port frame_err, output, 1, a one-clk pulse that flags a malformed frame.

Function
REQ-011 SHALL pass audio_sclk, audio_lrclk and audio_sdout through SYNC_STAGES flops each; operation is guaranteed for clk >= 4x sclk.
REQ-012 SHALL detect an sclk rising edge when the synchronized sclk changes from 0 to 1; all sampling happens on that one clk cycle.
REQ-013 SHALL capture, on each detected edge, the synchronized lrclk and sdout together; a captured lrclk differing from the previous captured value marks that bit as the first bit of the new channel (no one-bit delay).
REQ-014 SHALL assemble each channel word MSB first at index 15 down to 0, counting with a 5-bit bit_cnt that saturates at 16; bits after the 16th are discarded and missing LSBs are zero.
REQ-015 SHALL implement the FSM WAIT_SYNC -> LEFT on an lrclk 1->0 change; LEFT -> RIGHT on a 0->1 change, latching the left word into a hold register; RIGHT -> LEFT on a 1->0 change, latching the right word.
REQ-016 SHALL update sample_left and sample_right simultaneously, one clk after the detected edge that completes RIGHT, with sample_valid high for exactly that cycle.
REQ-017 SHALL hold sample_left and sample_right stable between valid pulses.
REQ-018 SHALL produce no sample_valid in WAIT_SYNC; the first pulse needs a complete left channel followed by a complete right channel.
REQ-019 SHALL, on a channel change, load the incoming bit as the new MSB and set bit_cnt to 1 in the same cycle that it closes the old word.
REQ-020 SHALL stay in the current state when sclk stops, with no timeout.

Reset
REQ-021 SHALL, on rst low, immediately drive sample_left = 0, sample_right = 0, sample_valid = 0 and frame_err = 0, clear the synchronizers, shift register, bit_cnt and hold register, and enter WAIT_SYNC.
REQ-022 SHALL, when reset is asserted mid-frame, discard the partial frame; after release it resynchronizes per REQ-015.

Configuration
REQ-023 SHALL, with AUDIO_RX_FRAME_ERR_EN defined, pulse frame_err together with sample_valid when either channel of that pair had a bit count other than 16 at its closing change (short, or long before saturation).
REQ-024 SHALL, without AUDIO_RX_FRAME_ERR_EN, tie frame_err to 0 and synthesize no count-compare logic; the data path is unchanged.

Structure
REQ-025 SHALL take SAMPLE_W = 16, BITS_PER_CH = 16 and the FSM state typedef (WAIT_SYNC, LEFT, RIGHT) from a shared audio package, which the transmitter side also uses.
REQ-026 SHALL instantiate the sub-module audio_sync_edge (SYNC_STAGES-deep synchronizer plus rise/change detect) once per external input.

Verification
REQ-027 SHALL be verified for a normal stream: clk 100 MHz, sclk 3.125 MHz, left 0xA5C3, right 0x1234, 16 bits per channel -> after the second full frame sample_left = 0xA5C3 and sample_right = 0x1234, sample_valid pulses once per frame and frame_err = 0.
REQ-028 SHALL be verified for start-up alignment: reset released while lrclk = 1 mid-right channel -> no sample_valid until lrclk 1->0, then a full left and right are received; the first pulse carries complete words.
REQ-029 SHALL be verified for a short channel: left sends 12 bits 0xFFF -> sample_left = 0xFFF0, and frame_err pulses with sample_valid when the macro is defined, otherwise stays 0.
REQ-030 SHALL be verified for a long channel: right sends 20 bits with the first 16 = 0x8001 -> sample_right = 0x8001, and frame_err pulses when the macro is defined.
REQ-031 SHALL be verified for reset mid-frame: rst pulsed low for 3 clk during bit 7 of left -> all outputs 0 immediately, and the next valid pair is the first full frame after resync.
REQ-032 SHALL be verified for sclk stall: sclk held at 0 for 10 us mid-left, then resumed -> no spurious sample_valid, and the word completes correctly.
